// File: rtl/ads131a0x_pkg.sv
// Shared constants for the ADS131A0x SPI responder: opcodes, lock/run states and status words.
package ads131a0x_pkg;

  typedef enum logic [1:0] {
    StPowerup  = 2'd0,
    StLocked   = 2'd1,
    StUnlocked = 2'd2,
    StRunning  = 2'd3
  } resp_state_e;

  localparam logic [15:0] CmdNull    = 16'h0000;
  localparam logic [15:0] CmdUnlock  = 16'h0655;
  localparam logic [15:0] CmdLock    = 16'h0555;
  localparam logic [15:0] CmdWakeup  = 16'h0033;
  localparam logic [15:0] CmdStandby = 16'h0022;
  localparam logic [2:0]  OpRreg     = 3'b001;
  localparam logic [2:0]  OpWreg     = 3'b010;

  localparam logic [15:0] ReadyWord  = 16'hFF04;
  localparam logic [7:0]  StatPrefix = 8'h22;
  localparam logic [4:0]  AdcEnaAddr = 5'h0F;

  // Status reply to NULL once the device has left power-up.
  function automatic logic [15:0] stat_word(resp_state_e st);
    return {StatPrefix, 6'b0, st == StRunning, (st == StUnlocked) || (st == StRunning)};
  endfunction

endpackage

// File: rtl/ads131a0x_resp_regfile.sv
// 8-bit register file for the responder; out-of-range addresses read 0 and ignore writes.
module ads131a0x_resp_regfile
  import ads131a0x_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic       SPI_SCLK_Temp,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] adc_ena
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0] regs_q [NUM_REGS];

  always_ff @(posedge SPI_SCLK_Temp) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < NUM_REGS)) begin
      regs_q[wr_addr[IdxW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < NUM_REGS) begin
      rd_data = regs_q[rd_addr[IdxW-1:0]];
    end
  end

  always_comb begin
    adc_ena = '0;
    if (32'(AdcEnaAddr) < NUM_REGS) begin
      adc_ena = regs_q[AdcEnaAddr[IdxW-1:0]];
    end
  end

endmodule

// File: rtl/ads131a0x_spi_responder.sv
// ADC-side SPI responder: decodes 16-bit commands, answers one frame later, and emits
// synthetic channel data with DRDY while running.
module ads131a0x_spi_responder
  import ads131a0x_pkg::*;
#(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned NUM_WORDS = 1,
  parameter int unsigned NUM_REGS  = 16
) (
  input  logic        SPI_SCLK_Temp,
  input  logic        reset_n,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_drdy_n,
  output logic [1:0]  resp_state,
  output logic        cmd_strobe,
  output logic [15:0] cmd_word,
  output logic        cmd_err,
  output logic [7:0]  frame_count
);

  localparam int unsigned FrameBits = WORD_BITS * NUM_WORDS;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);
  localparam logic [CntW-1:0] LastEdge   = CntW'(FrameBits);
  localparam logic [CntW-1:0] DecodeEdge = CntW'(17);

  logic [CntW-1:0]      bit_cnt_q, edge_num, miso_idx;
  logic [14:0]          cmd_sr_q;
  logic [15:0]          cmd_next;
  resp_state_e          state_q, dec_state;
  logic [15:0]          pending_q, dec_resp;
  logic                 dec_err, dec_wr, wr_en;
  logic [FrameBits-1:0] tx_q, tx_load, tx_shift;
  logic                 miso_q, drdy_n_q, strobe_q, err_q;
  logic [15:0]          cmd_word_q, sample_cnt_q;
  logic [7:0]           frame_cnt_q, rd_data, adc_ena, ena_sh;
  logic                 frame_end, decode_edge, shift_edge, unlocked_st;

  assign edge_num    = bit_cnt_q + CntW'(1);
  assign frame_end   = (edge_num == LastEdge);
  assign decode_edge = (edge_num == DecodeEdge);
  assign shift_edge  = (edge_num >= CntW'(2)) && (edge_num <= DecodeEdge);
  assign cmd_next    = {cmd_sr_q, spi_mosi};
  assign miso_idx    = LastEdge - edge_num;
  assign tx_shift    = tx_q >> miso_idx;
  assign unlocked_st = (state_q == StUnlocked) || (state_q == StRunning);
  assign wr_en       = reset_n && !spi_cs_n && decode_edge && dec_wr;

  ads131a0x_resp_regfile #(
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .SPI_SCLK_Temp(SPI_SCLK_Temp),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (cmd_next[12:8]),
    .wr_data      (cmd_next[7:0]),
    .rd_addr      (cmd_next[12:8]),
    .rd_data      (rd_data),
    .adc_ena      (adc_ena)
  );

  always_comb begin
    dec_state = state_q;
    dec_resp  = '0;
    dec_err   = 1'b0;
    dec_wr    = 1'b0;
    if (cmd_next == CmdNull) begin
      dec_resp = (state_q == StPowerup) ? ReadyWord : stat_word(state_q);
    end else if (cmd_next == CmdUnlock) begin
      if (state_q == StPowerup || state_q == StLocked) begin
        dec_state = StUnlocked;
        dec_resp  = cmd_next;
      end else begin
        dec_err = 1'b1;
      end
    end else if (cmd_next == CmdLock) begin
      if (unlocked_st) begin
        dec_state = StLocked;
        dec_resp  = cmd_next;
      end else begin
        dec_err = 1'b1;
      end
    end else if (cmd_next == CmdWakeup) begin
      if (state_q == StUnlocked) begin
        dec_state = StRunning;
        dec_resp  = cmd_next;
      end else begin
        dec_err = 1'b1;
      end
    end else if (cmd_next == CmdStandby) begin
      if (state_q == StRunning) begin
        dec_state = StUnlocked;
        dec_resp  = cmd_next;
      end else begin
        dec_err = 1'b1;
      end
    end else if (cmd_next[15:13] == OpRreg) begin
      if (state_q != StPowerup) begin
        dec_resp = {OpRreg, cmd_next[12:8], rd_data};
      end else begin
        dec_err = 1'b1;
      end
    end else if (cmd_next[15:13] == OpWreg) begin
      if (unlocked_st) begin
        dec_wr   = 1'b1;
        dec_resp = {OpRreg, cmd_next[12:0]};
      end else begin
        dec_err = 1'b1;
      end
    end else begin
      dec_err = 1'b1;
    end
  end

  // Frame image loaded at frame end: response in word 0, enabled channels in words 1..N-1.
  always_comb begin
    ena_sh  = '0;
    tx_load = FrameBits'(pending_q) << (FrameBits - 16);
    for (int i = 1; i < int'(NUM_WORDS); i++) begin
      ena_sh = adc_ena >> (i - 1);
      if (state_q == StRunning && ena_sh[0]) begin
        tx_load = tx_load | (FrameBits'(sample_cnt_q + 16'(i))
                  << ((int'(NUM_WORDS) - 1 - i) * int'(WORD_BITS) + int'(WORD_BITS) - 16));
      end
    end
  end

  always_ff @(posedge SPI_SCLK_Temp) begin
    if (!reset_n) begin
      bit_cnt_q    <= '0;
      cmd_sr_q     <= '0;
      state_q      <= StPowerup;
      pending_q    <= '0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      drdy_n_q     <= 1'b1;
      strobe_q     <= 1'b0;
      err_q        <= 1'b0;
      cmd_word_q   <= '0;
      frame_cnt_q  <= '0;
      sample_cnt_q <= '0;
    end else if (spi_cs_n) begin
      bit_cnt_q <= '0;
      cmd_sr_q  <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= frame_end ? '0 : edge_num;
      miso_q    <= tx_shift[0];
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      if (shift_edge) begin
        cmd_sr_q <= cmd_next[14:0];
      end
      if (edge_num == CntW'(1)) begin
        drdy_n_q <= 1'b1;
      end
      if (decode_edge) begin
        state_q    <= dec_state;
        pending_q  <= dec_resp;
        strobe_q   <= 1'b1;
        err_q      <= dec_err;
        cmd_word_q <= cmd_next;
        if (state_q == StRunning && dec_state != StRunning) begin
          drdy_n_q <= 1'b1;
        end
      end
      if (frame_end) begin
        tx_q        <= tx_load;
        frame_cnt_q <= frame_cnt_q + 8'd1;
        if (state_q == StRunning) begin
          drdy_n_q     <= 1'b0;
          sample_cnt_q <= sample_cnt_q + 16'd1;
        end
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_drdy_n  = drdy_n_q;
  assign resp_state  = state_q;
  assign cmd_strobe  = strobe_q;
  assign cmd_word    = cmd_word_q;
  assign cmd_err     = err_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_ads131a0x_spi_responder.sv
// Randomized bench for the ADS131A0x responder against a frame-level behavioural model.
module tb_ads131a0x_spi_responder;

  localparam int WB = 32;
  localparam int NW = 5;
  localparam int NR = 16;
  localparam int F  = WB * NW;

  logic        clk = 1'b0;
  logic        reset_n, cs_n, mosi;
  logic        miso, drdy_n, cmd_strobe, cmd_err;
  logic [1:0]  resp_state;
  logic [15:0] cmd_word;
  logic [7:0]  frame_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_st;
  logic [7:0]  m_regs [NR];
  logic [15:0] m_pend;
  logic [31:0] m_tx [NW];
  logic [15:0] m_samp;
  int          m_fc;
  logic        m_drdy;

  always #5 clk = ~clk;

  ads131a0x_spi_responder #(
    .WORD_BITS(WB),
    .NUM_WORDS(NW),
    .NUM_REGS (NR)
  ) dut (
    .SPI_SCLK_Temp(clk),
    .reset_n      (reset_n),
    .spi_cs_n     (cs_n),
    .spi_mosi     (mosi),
    .spi_miso     (miso),
    .spi_drdy_n   (drdy_n),
    .resp_state   (resp_state),
    .cmd_strobe   (cmd_strobe),
    .cmd_word     (cmd_word),
    .cmd_err      (cmd_err),
    .frame_count  (frame_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_pend = 16'h0;
    for (int i = 0; i < NW; i++) m_tx[i] = 32'h0;
    m_samp = 16'h0;
    m_fc   = 0;
    m_drdy = 1'b1;
  endtask

  // States: 0 powerup, 1 locked, 2 unlocked, 3 running.
  task automatic model_cmd(input logic [15:0] cmd, output bit err);
    bit unl;
    int a;
    int old_st;
    unl    = (m_st == 2) || (m_st == 3);
    a      = int'(cmd[12:8]);
    old_st = m_st;
    err    = 1'b0;
    if (cmd == 16'h0000) begin
      m_pend = (m_st == 0) ? 16'hFF04 : {8'h22, 6'b0, m_st == 3, unl};
    end else if (cmd == 16'h0655) begin
      if (m_st <= 1) m_st = 2; else err = 1'b1;
    end else if (cmd == 16'h0555) begin
      if (unl) m_st = 1; else err = 1'b1;
    end else if (cmd == 16'h0033) begin
      if (m_st == 2) m_st = 3; else err = 1'b1;
    end else if (cmd == 16'h0022) begin
      if (m_st == 3) m_st = 2; else err = 1'b1;
    end else if (cmd[15:13] == 3'b001) begin
      if (m_st != 0) m_pend = {3'b001, cmd[12:8], (a < NR) ? m_regs[a] : 8'h00};
      else err = 1'b1;
    end else if (cmd[15:13] == 3'b010) begin
      if (unl) begin
        if (a < NR) m_regs[a] = cmd[7:0];
        m_pend = {3'b001, cmd[12:0]};
      end else begin
        err = 1'b1;
      end
    end else begin
      err = 1'b1;
    end
    if (err) m_pend = 16'h0000;
    else if (cmd == 16'h0655 || cmd == 16'h0555 || cmd == 16'h0033 || cmd == 16'h0022)
      m_pend = cmd;
    if (old_st == 3 && m_st != 3) m_drdy = 1'b1;
  endtask

  task automatic model_frame_end();
    logic [7:0] ena;
    ena = m_regs[15];
    m_tx[0] = {m_pend, 16'h0};
    for (int i = 1; i < NW; i++) begin
      m_tx[i] = (m_st == 3 && ena[i-1]) ? {m_samp + 16'(i), 16'h0} : 32'h0;
    end
    if (m_st == 3) begin
      m_drdy = 1'b0;
      m_samp = m_samp + 16'd1;
    end
    m_fc = (m_fc + 1) % 256;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cs_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // abort_after: complete that many edges then raise cs_n (0 = full frame).
  // rst_at: assert reset on that edge of the frame (0 = none).
  task automatic run_frame(input logic [15:0] cmd, input int abort_after, input int rst_at);
    logic [31:0] rx [NW];
    logic [31:0] exp_tx [NW];
    bit ee;
    exp_tx = m_tx;
    for (int i = 0; i < NW; i++) rx[i] = 32'h0;
    for (int e = 1; e <= F; e++) begin
      if (abort_after > 0 && e == abort_after + 1) begin
        cs_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_strobe", 32'(cmd_strobe), 32'd0);
        check_eq("abort_state", 32'(resp_state), 32'(m_st));
        return;
      end
      cs_n = 1'b0;
      mosi = (e >= 2 && e <= 17) ? cmd[17-e] : 1'($urandom_range(0, 1));
      if (rst_at > 0 && e == rst_at) begin
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_eq("rst_state", 32'(resp_state), 32'd0);
        check_eq("rst_miso", 32'(miso), 32'd0);
        check_eq("rst_drdy", 32'(drdy_n), 32'd1);
        check_eq("rst_fc", 32'(frame_count), 32'd0);
        check_eq("rst_cmd_word", 32'(cmd_word), 32'd0);
        check_eq("rst_strobe", 32'(cmd_strobe), 32'd0);
        check_eq("rst_err", 32'(cmd_err), 32'd0);
        reset_n = 1'b1;
        cs_n    = 1'b1;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      rx[(e-1)/WB][WB-1-((e-1)%WB)] = miso;
      if (e == 1) begin
        check_eq("drdy_edge1", 32'(drdy_n), 32'd1);
        m_drdy = 1'b1;
      end
      if (e == 17) begin
        model_cmd(cmd, ee);
        check_eq("strobe", 32'(cmd_strobe), 32'd1);
        check_eq("cmd_word", 32'(cmd_word), 32'(cmd));
        check_eq("cmd_err", 32'(cmd_err), 32'(ee));
        check_eq("state", 32'(resp_state), 32'(m_st));
      end else if (e == 18) begin
        check_eq("strobe_pulse", 32'(cmd_strobe), 32'd0);
      end
      if (e == F) begin
        model_frame_end();
        for (int i = 0; i < NW; i++) check_eq($sformatf("miso_w%0d", i), rx[i], exp_tx[i]);
        check_eq("frame_count", 32'(frame_count), 32'(m_fc));
        check_eq("drdy_end", 32'(drdy_n), 32'(m_drdy));
      end
    end
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'h0655;
      2: return 16'h0555;
      3: return 16'h0033;
      4: return 16'h0022;
      5: return {3'b001, r[12:0]};
      6, 7: return {3'b010, r[12:0]};
      8: return r;
      default: return {8'h4F, r[7:0]};
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_eq("reset_state", 32'(resp_state), 32'd0);
    check_eq("reset_drdy", 32'(drdy_n), 32'd1);
    check_eq("reset_fc", 32'(frame_count), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Power-up NULLs, then unlock/configure/run sequence.
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);
    check_eq("fc_after_two", 32'(frame_count), 32'd2);
    run_frame(16'h0655, 0, 0);
    run_frame(16'h4F0F, 0, 0);
    run_frame(16'h0033, 0, 0);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);
    check_eq("running_drdy", 32'(drdy_n), 32'd0);
    run_frame(16'h4F05, 0, 0);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);

    // Locked: write rejected, read allowed.
    run_frame(16'h0555, 0, 0);
    run_frame(16'h4105, 0, 0);
    run_frame(16'h2100, 0, 0);
    run_frame(16'h0000, 0, 0);

    // Aborted UNLOCK leaves state and pending untouched.
    run_frame(16'h0655, 10, 0);
    idle(2);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);

    // Mid-frame reset, then a clean frame returns zeros.
    run_frame(16'h0655, 0, 20);
    idle(2);
    run_frame(16'h0000, 0, 0);
    run_frame(16'h0000, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_frame(rand_cmd(), int'($urandom_range(1, F - 1)), 0);
        idle(1);
      end else begin
        run_frame(rand_cmd(), 0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
